// File: rtl/asteroid_spawn_scheduler.sv
// ============================================================================
// asteroid_spawn_scheduler
//
// Purpose:
//   Sequences asteroid spawns. A tick-driven wave counter runs 1..PERIOD. Each
//   wrap queues one spawn request, up to PEND_MAX requests. Queued requests are
//   granted round-robin to free asteroid slots. Each grant carries a
//   pseudo-random x position and is offered over a valid/ready handshake.
//
// Ports:
//   clk          in   1          system clock, rising edge
//   reset        in   1          asynchronous reset, active-high
//   enable       in   1          1 = wave counter advances on tick
//   tick         in   1          one-cycle pulse advancing the wave counter
//   slot_busy    in   NUM_SLOTS  bit i = 1: slot i holds a live asteroid
//   spawn_ready  in   1          target slot accepts the spawn this cycle
//   spawn_valid  out  1          spawn offer valid
//   spawn_slot   out  SW         slot index of the offer
//   spawn_x      out  XW         x position of the offer, 0..X_MAX-1
//   count        out  10         wave counter, 1..PERIOD
//   pending      out  2          queued spawn requests, 0..PEND_MAX
//
// Optional feature (define SPAWN_OVF_EN):
//   ovf          out  1          sticky: a wrap was dropped at PEND_MAX
//   ovf_clr      in   1          clears ovf; a same-cycle set wins
// ============================================================================
module asteroid_spawn_scheduler #(
  parameter int PERIOD    = 500,
  parameter int NUM_SLOTS = 4,
  parameter int SW        = 2,
  parameter int XW        = 10,
  parameter int X_MAX     = 600,
  parameter int PEND_MAX  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 tick,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic                 spawn_ready,
`ifdef SPAWN_OVF_EN
  input  logic                 ovf_clr,
  output logic                 ovf,
`endif
  output logic                 spawn_valid,
  output logic [SW-1:0]        spawn_slot,
  output logic [XW-1:0]        spawn_x,
  output logic [9:0]           count,
  output logic [1:0]           pending
);

  localparam logic [9:0]  PERIOD_C   = 10'(PERIOD);
  localparam logic [1:0]  PEND_MAX_C = 2'(PEND_MAX);
  localparam logic [10:0] X_MAX_C    = 11'(X_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    OFFER = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] last_grant;
  logic [9:0]    lfsr;

  logic          wrap;
  logic          handshake;
  logic          any_free;
  logic          grant_found;
  logic [SW-1:0] grant_slot;
  logic [SW-1:0] cand;
  logic [10:0]   x_wide;

  assign wrap      = tick & enable & (count == PERIOD_C);
  assign handshake = spawn_valid & spawn_ready;
  assign any_free  = |(~slot_busy);

  // Round-robin search. Offsets are scanned from farthest to nearest, so the
  // nearest free slot after last_grant is the one left in grant_slot. The
  // SW-bit addition wraps modulo NUM_SLOTS because NUM_SLOTS is a power of two.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    grant_found = 1'b0;
    grant_slot  = '0;
    cand        = '0;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      cand = last_grant + SW'(k);
      if (!slot_busy[cand]) begin
        grant_found = 1'b1;
        grant_slot  = cand;
      end
    end
  end

  // Fold the LFSR value into 0..X_MAX-1. One subtraction is enough because
  // X_MAX >= 2^(XW-1).
  always_comb begin
    x_wide = {1'b0, lfsr};
    if (x_wide >= X_MAX_C) begin
      x_wide = x_wide - X_MAX_C;
    end
  end

  // Wave counter, pending-request queue depth and LFSR.
  // NOTE: sequential state is written with non-blocking assignments, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 10'd1;
      pending <= 2'd0;
      lfsr    <= 10'h001;
    end else begin
      if (tick && enable) begin
        count <= wrap ? 10'd1 : count + 10'd1;
      end

      // A wrap together with a handshake cancels out. A wrap at the ceiling
      // is dropped.
      if (wrap && !handshake) begin
        if (pending != PEND_MAX_C) begin
          pending <= pending + 2'd1;
        end
      end else if (handshake && !wrap) begin
        pending <= pending - 2'd1;
      end

      // Fibonacci LFSR, x^10 + x^7 + 1. The all-zero state is unreachable
      // from the seed 10'h001.
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  end

`ifdef SPAWN_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wrap && (pending == PEND_MAX_C) && !handshake) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

  // Grant FSM with registered offer outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= SW'(NUM_SLOTS - 1);
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_x     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((pending != 2'd0) && any_free) begin
            state <= ARB;
          end
        end
        ARB: begin
          // slot_busy may change between IDLE and ARB. If no slot is free
          // now, go back to IDLE; the request stays queued.
          if (grant_found) begin
            spawn_slot  <= grant_slot;
            spawn_x     <= x_wide[XW-1:0];
            spawn_valid <= 1'b1;
            state       <= OFFER;
          end else begin
            state <= IDLE;
          end
        end
        OFFER: begin
          // The offer is held until accepted. slot_busy is not examined here.
          if (spawn_ready) begin
            spawn_valid <= 1'b0;
            last_grant  <= spawn_slot;
            state       <= IDLE;
          end
        end
        default: begin
          spawn_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asteroid_spawn_scheduler.sv
// ============================================================================
// tb_asteroid_spawn_scheduler
//
// Purpose:
//   Self-checking bench for asteroid_spawn_scheduler with default parameters.
//   The expected slot of each handshake is queued when the wraps are driven.
//   The queue is popped when the handshake is observed. Each spawn_x is
//   compared against an independent LFSR reference, and offers are checked
//   for stability while they are held.
// ============================================================================
`timescale 1ns/1ps
module tb_asteroid_spawn_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       tick;
  logic [3:0] slot_busy;
  logic       spawn_ready;
  logic       spawn_valid;
  logic [1:0] spawn_slot;
  logic [9:0] spawn_x;
  logic [9:0] count;
  logic [1:0] pending;
`ifdef SPAWN_OVF_EN
  logic       ovf;
  logic       ovf_clr;
`endif

  int checks = 0;
  int errors = 0;

  int         sb[$];
  logic [9:0] lfsr_m;
  logic [9:0] lfsr_hist;
  logic       prev_valid = 1'b0;
  logic [1:0] held_slot  = '0;
  logic [9:0] held_x     = '0;

  always #5 clk = ~clk;

  asteroid_spawn_scheduler dut (
    .clk         (clk),
    .reset       (rst),
    .enable      (enable),
    .tick        (tick),
    .slot_busy   (slot_busy),
    .spawn_ready (spawn_ready),
`ifdef SPAWN_OVF_EN
    .ovf_clr     (ovf_clr),
    .ovf         (ovf),
`endif
    .spawn_valid (spawn_valid),
    .spawn_slot  (spawn_slot),
    .spawn_x     (spawn_x),
    .count       (count),
    .pending     (pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] fold_x(input logic [9:0] v);
    return (v >= 10'd600) ? v - 10'd600 : v;
  endfunction

  // Reference LFSR (x^10 + x^7 + 1, seed 1). lfsr_hist holds the value from
  // before the most recent edge, which is the value the ARB edge latches.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_m    <= 10'h001;
      lfsr_hist <= 10'h001;
    end else begin
      lfsr_hist <= lfsr_m;
      lfsr_m    <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    end
  end

  // Offer monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (spawn_valid) begin
        if (!prev_valid) begin
          check("spawn_x_value", 32'(spawn_x), 32'(fold_x(lfsr_hist)));
          check("spawn_x_range", 32'(spawn_x < 10'd600), 32'd1);
          held_slot = spawn_slot;
          held_x    = spawn_x;
        end else begin
          check("slot_stable", 32'(spawn_slot), 32'(held_slot));
          check("x_stable", 32'(spawn_x), 32'(held_x));
        end
        if (spawn_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_handshake", 32'd1, 32'd0);
          end else begin
            check("spawn_slot", 32'(spawn_slot), 32'(sb.pop_front()));
          end
        end
      end
      prev_valid = spawn_valid;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    wait_cycles(n);
    tick = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b1;
    tick        = 1'b0;
    slot_busy   = 4'b0000;
    spawn_ready = 1'b1;
`ifdef SPAWN_OVF_EN
    ovf_clr     = 1'b0;
`endif
    #3;
    check("rst_count", 32'(count), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_valid", 32'(spawn_valid), 32'd0);
    check("rst_slot", 32'(spawn_slot), 32'd0);
    check("rst_x", 32'(spawn_x), 32'd0);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: counter reaches PERIOD, then wraps and queues one request.
    do_ticks(499);
    check("t1_count_500", 32'(count), 32'd500);
    check("t1_pending_0", 32'(pending), 32'd0);
    sb.push_back(0);
    do_ticks(1);
    check("t1_count_wrap", 32'(count), 32'd1);
    check("t1_pending_1", 32'(pending), 32'd1);
    // Latency: the offer appears two clocks after pending becomes 1.
    wait_cycles(1);
    check("t1_valid_early", 32'(spawn_valid), 32'd0);
    wait_cycles(1);
    check("t1_valid_lat2", 32'(spawn_valid), 32'd1);
    wait_cycles(4);
    check("t1_pending_drain", 32'(pending), 32'd0);

    // 2: round-robin over free slots after a fresh reset.
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(2);
    do_ticks(1500);
    wait_cycles(8);
    check("t2_pending_0", 32'(pending), 32'd0);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: skip busy slots; hold the request while every slot is busy.
    slot_busy = 4'b1011;
    sb.push_back(2);
    do_ticks(500);
    wait_cycles(8);
    check("t3_pending_0", 32'(pending), 32'd0);
    slot_busy = 4'b1111;
    do_ticks(500);
    wait_cycles(10);
    check("t3_no_valid", 32'(spawn_valid), 32'd0);
    check("t3_pending_held", 32'(pending), 32'd1);
    sb.push_back(3);
    slot_busy = 4'b0111;
    wait_cycles(8);
    check("t3_pending_done", 32'(pending), 32'd0);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: saturate pending at 3 while the offer is stalled.
    slot_busy   = 4'b0000;
    spawn_ready = 1'b0;
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(2);
    do_ticks(2500);
    check("t4_pending_sat", 32'(pending), 32'd3);
    check("t4_valid_held", 32'(spawn_valid), 32'd1);
    check("t4_slot", 32'(spawn_slot), 32'd0);
`ifdef SPAWN_OVF_EN
    check("t4_ovf_set", 32'(ovf), 32'd1);
    wait_cycles(3);
    check("t4_ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    wait_cycles(1);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(ovf), 32'd0);
`endif
    spawn_ready = 1'b1;
    wait_cycles(15);
    check("t4_pending_drain", 32'(pending), 32'd0);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: wrap and handshake on the same edge leave pending unchanged.
    spawn_ready = 1'b0;
    sb.push_back(3);
    sb.push_back(0);
    do_ticks(500);
    do_ticks(499);
    check("t5_count_500", 32'(count), 32'd500);
    check("t5_offer_open", 32'(spawn_valid), 32'd1);
    check("t5_pending_pre", 32'(pending), 32'd1);
    spawn_ready = 1'b1;
    do_ticks(1);
    check("t5_pending_same", 32'(pending), 32'd1);
    check("t5_count_wrap", 32'(count), 32'd1);
    wait_cycles(8);
    check("t5_pending_drain", 32'(pending), 32'd0);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: asynchronous reset during an offer; enable=0 freezes the counter.
    spawn_ready = 1'b0;
    do_ticks(500);
    do_ticks(7);
    check("t6_offer_open", 32'(spawn_valid), 32'd1);
    check("t6_count_pre", 32'(count), 32'd8);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(spawn_valid), 32'd0);
    check("t6_rst_count", 32'(count), 32'd1);
    check("t6_rst_pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b0;
    do_ticks(50);
    check("t6_count_frozen", 32'(count), 32'd1);
    check("t6_no_valid", 32'(spawn_valid), 32'd0);
    enable = 1'b1;
    do_ticks(5);
    check("t6_count_resume", 32'(count), 32'd6);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
